mtimer_periph: RTL and testbench

- Memory-mapped machine timer. It is the responder on the processor's load/store interface (rd_en, wr_en, mem_type, addr, wdata, rdata).
- It is also the source of the processor's timer_interrupt line into the CSR trap logic.
- Holds a 64-bit mtime counter advanced by a programmable prescaler, and a 64-bit mtimecmp compare register.
- Raises timer_interrupt when enabled and mtime >= mtimecmp. Sits beside data_mem; the top level muxes rdata on hit.

---
 rtl/mtimer_periph.sv | 137 +++++++++++++
 tb/tb_mtimer_periph.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtimer_periph.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp, level interrupt.
// Optional MTIMER_STATUS_EN adds a sticky STATUS.PEND at offset 0x18 that drives the interrupt.
module mtimer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mem_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        timer_interrupt
);

  localparam logic [2:0] SEL_MTIME_LO = 3'd0;
  localparam logic [2:0] SEL_MTIME_HI = 3'd1;
  localparam logic [2:0] SEL_CMP_LO   = 3'd2;
  localparam logic [2:0] SEL_CMP_HI   = 3'd3;
  localparam logic [2:0] SEL_CTRL     = 3'd4;
  localparam logic [2:0] SEL_PRESC    = 3'd5;
  localparam logic [2:0] SEL_STATUS   = 3'd6;

  logic [31:0]        mtime_lo_reg, mtime_hi_reg;
  logic [31:0]        cmp_lo_reg, cmp_hi_reg;
  logic               en_reg, ie_reg;
  logic [PRESC_W-1:0] presc_reg, count_reg;
  logic               irq_reg;

  logic               in_win, aligned, wr_ok;
  logic [2:0]         reg_sel;
  logic               wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_presc;
  logic               tick, cmp_ge;
  logic [32:0]        lo_sum;
  logic [31:0]        mtime_lo_next, mtime_hi_next;
  logic [PRESC_W-1:0] count_next;
  logic               irq_next;
  logic [31:0]        read_val;

  assign in_win  = (addr[31:5] == BASE_ADDR[31:5]);
  assign hit     = in_win & (rd_en | wr_en);
  assign aligned = (addr[1:0] == 2'b00);
  assign reg_sel = addr[4:2];
  assign wr_ok   = hit & wr_en & (mem_type == 3'b010) & aligned;

  assign wr_mtime_lo = wr_ok & (reg_sel == SEL_MTIME_LO);
  assign wr_mtime_hi = wr_ok & (reg_sel == SEL_MTIME_HI);
  assign wr_cmp_lo   = wr_ok & (reg_sel == SEL_CMP_LO);
  assign wr_cmp_hi   = wr_ok & (reg_sel == SEL_CMP_HI);
  assign wr_ctrl     = wr_ok & (reg_sel == SEL_CTRL);
  assign wr_presc    = wr_ok & (reg_sel == SEL_PRESC);

  assign tick   = en_reg & (count_reg == presc_reg);
  assign cmp_ge = {mtime_hi_reg, mtime_lo_reg} >= {cmp_hi_reg, cmp_lo_reg};

  // The tick's carry out of LO reaches HI even when software overwrites LO this cycle.
  assign lo_sum        = {1'b0, mtime_lo_reg} + 33'(tick);
  assign mtime_lo_next = wr_mtime_lo ? wdata : lo_sum[31:0];
  assign mtime_hi_next = wr_mtime_hi ? wdata : mtime_hi_reg + 32'(lo_sum[32]);

  always_comb begin
    count_next = count_reg;
    if (wr_presc || tick) begin
      count_next = '0;
    end else if (en_reg) begin
      count_next = count_reg + 1'b1;
    end
  end

`ifdef MTIMER_STATUS_EN
  logic pend_reg, pend_next, wr_status;

  assign wr_status = wr_ok & (reg_sel == SEL_STATUS);
  // Set has priority over the write-1-to-clear.
  assign pend_next = (en_reg & cmp_ge) | (pend_reg & ~(wr_status & wdata[0]));
  assign irq_next  = ie_reg & pend_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= 1'b0;
    end else begin
      pend_reg <= pend_next;
    end
  end
`else
  assign irq_next = en_reg & ie_reg & cmp_ge;
`endif

  always_comb begin
    read_val = '0;
    case (reg_sel)
      SEL_MTIME_LO: read_val = mtime_lo_reg;
      SEL_MTIME_HI: read_val = mtime_hi_reg;
      SEL_CMP_LO:   read_val = cmp_lo_reg;
      SEL_CMP_HI:   read_val = cmp_hi_reg;
      SEL_CTRL:     read_val = {30'd0, ie_reg, en_reg};
      SEL_PRESC:    read_val = 32'(presc_reg);
`ifdef MTIMER_STATUS_EN
      SEL_STATUS:   read_val = {31'd0, pend_reg};
`endif
      default:      read_val = '0;
    endcase
  end

  assign rdata           = (hit & rd_en & aligned) ? read_val : 32'd0;
  assign timer_interrupt = irq_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_lo_reg <= '0;
      mtime_hi_reg <= '0;
      cmp_lo_reg   <= '1;
      cmp_hi_reg   <= '1;
      en_reg       <= 1'b0;
      ie_reg       <= 1'b0;
      presc_reg    <= '0;
      count_reg    <= '0;
      irq_reg      <= 1'b0;
    end else begin
      mtime_lo_reg <= mtime_lo_next;
      mtime_hi_reg <= mtime_hi_next;
      count_reg    <= count_next;
      irq_reg      <= irq_next;
      if (wr_cmp_lo) cmp_lo_reg <= wdata;
      if (wr_cmp_hi) cmp_hi_reg <= wdata;
      if (wr_ctrl) begin
        en_reg <= wdata[0];
        ie_reg <= wdata[1];
      end
      if (wr_presc) presc_reg <= wdata[PRESC_W-1:0];
    end
  end

endmodule

// File: tb/tb_mtimer_periph.sv
// Self-checking bench for mtimer_periph: directed scenarios plus randomized bus traffic
// checked against a cycle-level arithmetic model of the timer.
module tb_mtimer_periph;

  localparam logic [31:0] BASE = 32'h0000_0400;
`ifdef MTIMER_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  mem_type = 3'b010;
  logic [31:0] addr = BASE;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        hit;
  logic        timer_interrupt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mtimer_periph #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .mem_type(mem_type),
    .addr(addr), .wdata(wdata), .rdata(rdata), .hit(hit), .timer_interrupt(timer_interrupt)
  );

  // Reference model: whole 64-bit quantities and plain arithmetic, advanced once per clock.
  logic [63:0] m_mtime, m_cmp;
  logic        m_en, m_ie, m_irq, m_pend;
  logic [15:0] m_presc, m_cnt;
  logic        m_wr, m_tick, m_ge;
  logic [4:0]  m_off;

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd32);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (!in_window(a) || a[1:0] != 2'b00) return 32'd0;
    case (a - BASE)
      32'h00: return m_mtime[31:0];
      32'h04: return m_mtime[63:32];
      32'h08: return m_cmp[31:0];
      32'h0C: return m_cmp[63:32];
      32'h10: return {30'd0, m_ie, m_en};
      32'h14: return {16'd0, m_presc};
      32'h18: return STATUS ? {31'd0, m_pend} : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mtime = 64'd0; m_cmp = '1; m_en = 0; m_ie = 0;
      m_presc = 0; m_cnt = 0; m_irq = 0; m_pend = 0;
    end else begin
      m_wr   = wr_en && in_window(addr) && mem_type == 3'b010 && addr[1:0] == 2'b00;
      m_off  = 5'(addr - BASE);
      m_tick = m_en && (m_cnt == m_presc);
      m_ge   = m_mtime >= m_cmp;
      m_irq  = STATUS ? (m_ie && m_pend) : (m_en && m_ie && m_ge);
      m_pend = (m_en && m_ge) || (m_pend && !(m_wr && m_off == 5'h18 && wdata[0]));
      if (m_en) m_cnt = m_tick ? 16'd0 : m_cnt + 16'd1;
      m_mtime = m_mtime + 64'(m_tick);
      if (m_wr) begin
        case (m_off)
          5'h00: m_mtime[31:0]  = wdata;
          5'h04: m_mtime[63:32] = wdata;
          5'h08: m_cmp[31:0]    = wdata;
          5'h0C: m_cmp[63:32]   = wdata;
          5'h10: begin m_en = wdata[0]; m_ie = wdata[1]; end
          5'h14: begin m_presc = wdata[15:0]; m_cnt = 16'd0; end
          default: ;
        endcase
      end
    end
  end

  // Bus helpers: entered just after a falling edge, return just after the next one.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] mt = 3'b010);
    wr_en = 1'b1; addr = a; wdata = d; mem_type = mt;
    @(negedge clk);
    wr_en = 1'b0; mem_type = 3'b010;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    rd_en = 1'b1; addr = a;
    #1;
    d = rdata; h = hit;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic        h;
    logic [31:0] exp_vals [4];
    logic [31:0] offs [4];
    exp_vals = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    offs     = '{32'h00, 32'h08, 32'h0C, 32'h10};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_read(BASE + offs[i], d, h);
      checks++;
      if (d !== exp_vals[i] || h !== 1'b1) begin
        errors++;
        $display("FAIL reset_read off=%0h got=%h hit=%b want=%h hit=1", offs[i], d, h, exp_vals[i]);
      end
    end
    checks++;
    if (timer_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got=%b want=0", timer_interrupt);
    end
    $display("reset: registers and interrupt checked");
  endtask

  task automatic test_prescale;
    logic [31:0] d;
    logic        h;
    bus_write(BASE + 32'h14, 32'd3);
    bus_write(BASE + 32'h10, 32'd1);
    repeat (40) @(negedge clk);
    bus_read(BASE + 32'h00, d, h);
    checks++;
    if (d !== 32'd10) begin
      errors++;
      $display("FAIL prescale_mtime got=%0d want=10", d);
    end
    $display("prescale: PRESCALE=3 for 40 cycles -> MTIME_LO=%0d", d);
  endtask

  task automatic test_carry;
    logic [31:0] d_lo, d_hi;
    logic        h;
    bus_write(BASE + 32'h10, 32'd0);
    bus_write(BASE + 32'h14, 32'd0);
    bus_write(BASE + 32'h00, 32'hFFFF_FFFE);
    bus_write(BASE + 32'h04, 32'd0);
    bus_write(BASE + 32'h10, 32'd1);
    repeat (2) @(negedge clk);
    bus_read(BASE + 32'h00, d_lo, h);
    bus_read(BASE + 32'h04, d_hi, h);
    checks++;
    if (d_lo !== 32'd0 || d_hi !== 32'd1) begin
      errors++;
      $display("FAIL carry got lo=%h hi=%h want lo=0 hi=1", d_lo, d_hi);
    end
    $display("carry: lo=%h hi=%h after two ticks from FFFFFFFE", d_lo, d_hi);
  endtask

  task automatic test_irq;
    logic exp_irq;
    bus_write(BASE + 32'h10, 32'd0);
    bus_write(BASE + 32'h14, 32'd0);
    bus_write(BASE + 32'h0C, 32'd0);
    bus_write(BASE + 32'h08, 32'd20);
    bus_write(BASE + 32'h00, 32'd0);
    bus_write(BASE + 32'h04, 32'd0);
    bus_write(BASE + 32'h10, 32'd3);
    // mtime reaches 20 after 20 ticks; the interrupt register lags by one (two with PEND).
    for (int i = 1; i <= 26; i++) begin
      @(negedge clk);
      exp_irq = STATUS ? (i >= 22) : (i >= 21);
      checks++;
      if (timer_interrupt !== exp_irq) begin
        errors++;
        $display("FAIL irq_rise cycle=%0d got=%b want=%b", i, timer_interrupt, exp_irq);
      end
    end
    bus_write(BASE + 32'h08, 32'd1000);
    checks++;
    if (timer_interrupt !== 1'b1) begin
      errors++;
      $display("FAIL irq_hold_after_cmp_write got=%b want=1", timer_interrupt);
    end
    @(negedge clk);
    exp_irq = STATUS;
    checks++;
    if (timer_interrupt !== exp_irq) begin
      errors++;
      $display("FAIL irq_after_cmp_raise got=%b want=%b", timer_interrupt, exp_irq);
    end
    $display("irq: rise and response to MTIMECMP_LO=1000 checked");
  endtask

  task automatic test_status;
    logic [31:0] d;
    logic        h;
    bus_read(BASE + 32'h18, d, h);
    checks++;
    if (d !== 32'(STATUS)) begin
      errors++;
      $display("FAIL status_read got=%h want=%h", d, 32'(STATUS));
    end
    bus_write(BASE + 32'h18, 32'd1);
    checks++;
    if (timer_interrupt !== STATUS) begin
      errors++;
      $display("FAIL status_clear_edge got=%b want=%b", timer_interrupt, STATUS);
    end
    @(negedge clk);
    checks++;
    if (timer_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL status_after_clear got=%b want=0", timer_interrupt);
    end
    bus_read(BASE + 32'h18, d, h);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL status_cleared got=%h want=0", d);
    end
    $display("status: read, write-1-to-clear and interrupt drop checked");
  endtask

  task automatic test_illegal;
    logic [31:0] d;
    logic        h;
    bus_write(BASE + 32'h10, 32'd0);
    bus_write(BASE + 32'h10, 32'd3, 3'b000);
    bus_write(BASE + 32'h12, 32'd3);
    bus_read(BASE + 32'h10, d, h);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL illegal_store_ctrl got=%h want=0", d);
    end
    bus_read(BASE + 32'h20, d, h);
    checks++;
    if (d !== 32'd0 || h !== 1'b0) begin
      errors++;
      $display("FAIL out_of_window got=%h hit=%b want=0 hit=0", d, h);
    end
    bus_read(BASE + 32'h0A, d, h);
    checks++;
    if (d !== 32'd0 || h !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_read got=%h hit=%b want=0 hit=1", d, h);
    end
    $display("illegal: sub-word/misaligned stores dropped, window decode checked");
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic        h;
    bus_write(BASE + 32'h08, 32'h55);
    rd_en = 1'b1; wr_en = 1'b1; addr = BASE + 32'h08; wdata = 32'hAA;
    #1;
    checks++;
    if (rdata !== 32'h55) begin
      errors++;
      $display("FAIL rd_wr_same_cycle got=%h want=55", rdata);
    end
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    bus_read(BASE + 32'h08, d, h);
    checks++;
    if (d !== 32'hAA) begin
      errors++;
      $display("FAIL rd_wr_written got=%h want=aa", d);
    end
    $display("back_to_back: read shows pre-write value, write lands");
  endtask

  task automatic test_random;
    logic [31:0] a, exp_d;
    logic        exp_h;
    int          op;
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 9));
      case ($urandom_range(0, 9))
        0:       a = BASE + 32'h20;
        1:       a = BASE + 32'($urandom_range(0, 31));
        default: a = BASE + 32'($urandom_range(0, 7) * 4);
      endcase
      addr = a;
      mem_type = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 5)) : 3'b010;
      case (a - BASE)
        32'h04, 32'h0C: wdata = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
        32'h10:         wdata = 32'($urandom_range(0, 3));
        32'h14:         wdata = 32'($urandom_range(0, 3));
        default:        wdata = 32'($urandom_range(0, 63));
      endcase
      rd_en = (op <= 4) || (op == 9);
      wr_en = (op >= 5);
      #1;
      exp_d = rd_en ? model_rd(a) : 32'd0;
      exp_h = in_window(a) && (rd_en || wr_en);
      checks++;
      if (rdata !== exp_d || hit !== exp_h || timer_interrupt !== m_irq) begin
        errors++;
        $display("FAIL random n=%0d addr=%h rd=%b wr=%b got=%h/%b/%b want=%h/%b/%b",
                 n, a, rd_en, wr_en, rdata, hit, timer_interrupt, exp_d, exp_h, m_irq);
      end
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0;
    end
    $display("random: 400 bus transactions compared with the model");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_prescale();
    test_carry();
    test_irq();
    test_status();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
